// File: rtl/types_pkg.sv
// Shared types for the RV32 pipeline: register addresses, forward selects,
// and the data-memory wait FSM states used by the hazard unit.
package types_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    // x0 is hardwired to zero, so it is never a forwarding target; M is newer than W.
    function automatic fwd_sel_t fwd_select(
        input reg_addr_t rs,
        input reg_addr_t rd_m,
        input logic      we_m,
        input reg_addr_t rd_w,
        input logic      we_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (rs != '0 && we_m && rs == rd_m)
            sel = FWD_M;
        else if (rs != '0 && we_w && rs == rd_w)
            sel = FWD_W;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Datapath <-> hazard unit bundle: register addresses and control bits in,
// stall/flush/forward controls, watchdog flag and performance counters out.
interface hazard_unit_if
    import types_pkg::*;
#(
    parameter int CNT_WIDTH = 32
);
    reg_addr_t Rs1D, Rs2D;
    reg_addr_t Rs1E, Rs2E, RdE;
    reg_addr_t RdM, RdW;
    logic      RegWriteM, RegWriteW;
    logic      ResultSrcE0;
    logic      PCSrcE;
    logic      mem_req_M;
    logic      mem_ready;

    logic      StallF, StallD, StallE, StallM, StallW;
    logic      FlushD, FlushE;
    fwd_sel_t  ForwardAE, ForwardEE;
    logic      mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cycles, flush_count, lu_count;

    // Datapath side.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, mem_req_M, mem_ready,
        input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        input  ForwardAE, ForwardEE, mem_timeout, stall_cycles, flush_count, lu_count
    );

    // Hazard unit side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, mem_req_M, mem_ready,
        output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        output ForwardAE, ForwardEE, mem_timeout, stall_cycles, flush_count, lu_count
    );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous reset.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, EX forwarding,
// data-memory wait freeze with watchdog, and saturating performance counters.
module hazard_unit
    import types_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int MAX_WAIT  = 255
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    mem_state_t        state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lw_stall, mem_stall;
    logic              stall_f, flush_inc, lu_inc;

    always_comb begin
        lw_stall  = hz.ResultSrcE0 && (hz.RdE != '0) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
        mem_stall = hz.mem_req_M && !hz.mem_ready;
    end

    // NOTE: every output gets a default first so no path through the block
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        stall_f      = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.StallM    = 1'b0;
        hz.StallW    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.ForwardAE = FWD_RF;
        hz.ForwardEE = FWD_RF;

        if (reset) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else begin
            hz.ForwardAE = fwd_select(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
            hz.ForwardEE = fwd_select(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
            if (mem_stall) begin
                // Whole-pipe freeze; W is held rather than bubbled so its
                // forwarding source stays valid while E waits.
                stall_f   = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                hz.StallW = 1'b1;
            end else begin
                stall_f   = lw_stall;
                hz.StallD = lw_stall;
                hz.FlushD = hz.PCSrcE;
                hz.FlushE = lw_stall || hz.PCSrcE;
            end
        end
    end

    assign hz.StallF = stall_f;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (mem_stall)    state_next = MEM_WAIT;
            MEM_WAIT: if (hz.mem_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Watchdog: counts cycles spent in MEM_WAIT; the error flag rises on the
    // edge where the count reaches MAX_WAIT and is cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt       <= '0;
            hz.mem_timeout <= 1'b0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else begin
            if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_LAST)
                hz.mem_timeout <= 1'b1;
        end
    end

    assign flush_inc = hz.PCSrcE && !mem_stall;
    assign lu_inc    = lw_stall && !mem_stall;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_f),
        .count (hz.stall_cycles)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (hz.flush_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_lu_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lu_inc),
        .count (hz.lu_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table for combinational controls,
// hand sequences for load-use, memory freeze, watchdog, reset and saturation.
module tb_hazard_unit;
    import types_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_unit_if #(.CNT_WIDTH(32)) hz ();
    hazard_unit_if #(.CNT_WIDTH(2))  hz2 ();

    hazard_unit #(.CNT_WIDTH(32), .MAX_WAIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    hazard_unit #(.CNT_WIDTH(2), .MAX_WAIT(255)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .hz    (hz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, ld, pcsrc, mreq, mrdy;
        logic [4:0] stalls;   // {F, D, E, M, W}
        logic [1:0] flushes;  // {D, E}
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] stalls_now();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW};
    endfunction

    function automatic logic [1:0] flushes_now();
        return {hz.FlushD, hz.FlushE};
    endfunction

    task automatic clear_inputs();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE0 = 1'b0;
        hz.PCSrcE = 1'b0; hz.mem_req_M = 1'b0; hz.mem_ready = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e;
        hz.RdE = v.rde; hz.RdM = v.rdm; hz.RdW = v.rdw;
        hz.RegWriteM = v.rwm; hz.RegWriteW = v.rww; hz.ResultSrcE0 = v.ld;
        hz.PCSrcE = v.pcsrc; hz.mem_req_M = v.mreq; hz.mem_ready = v.mrdy;
    endtask

    // Ends on a negedge with reset released and inputs idle.
    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_inputs();
        hz2.Rs1D = '0; hz2.Rs2D = '0; hz2.Rs1E = '0; hz2.Rs2E = '0;
        hz2.RdE = '0; hz2.RdM = '0; hz2.RdW = '0;
        hz2.RegWriteM = 1'b0; hz2.RegWriteW = 1'b0; hz2.ResultSrcE0 = 1'b0;
        hz2.PCSrcE = 1'b0; hz2.mem_req_M = 1'b0; hz2.mem_ready = 1'b0;

        //            rs1d rs2d rs1e rs2e rde rdm rdw rwm rww ld pc mq mr stalls    fl     fa     fb
        vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b00};
        vecs[1]  = '{0, 0, 0, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b00};
        vecs[3]  = '{0, 0, 9, 7, 0, 7, 9, 1, 1, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b10};
        vecs[4]  = '{0, 0, 7, 7, 0, 7, 7, 0, 1, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00};
        vecs[6]  = '{0, 3, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11000, 2'b01, 2'b00, 2'b00};
        vecs[7]  = '{3, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11000, 2'b01, 2'b00, 2'b00};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00};
        vecs[9]  = '{3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 2'b11, 2'b00, 2'b00};
        vecs[11] = '{3, 0, 0, 0, 3, 0, 0, 0, 0, 1, 1, 0, 0, 5'b11000, 2'b11, 2'b00, 2'b00};
        vecs[12] = '{0, 4, 0, 0, 4, 0, 0, 0, 0, 1, 0, 1, 1, 5'b11000, 2'b01, 2'b00, 2'b00};

        // Reset dominates every hazard and the memory freeze.
        @(negedge clk);
        apply('{3, 0, 5, 0, 3, 5, 5, 1, 1, 1, 1, 1, 0, 5'b0, 2'b0, 2'b0, 2'b0});
        #2;
        check("rst_stalls", 32'(stalls_now()), 32'h0);
        check("rst_flushes", 32'(flushes_now()), 32'h3);
        check("rst_fwd_a", 32'(hz.ForwardAE), 32'(FWD_RF));
        @(negedge clk);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_timeout", 32'(hz.mem_timeout), 32'h0);
        check("rst_stall_cycles", hz.stall_cycles, 32'h0);
        check("rst_flush_count", hz.flush_count, 32'h0);
        check("rst_lu_count", hz.lu_count, 32'h0);
        reset = 1'b0;
        clear_inputs();

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #2;
            check($sformatf("vec%0d_stalls", i), 32'(stalls_now()), 32'(vecs[i].stalls));
            check($sformatf("vec%0d_flushes", i), 32'(flushes_now()), 32'(vecs[i].flushes));
            check($sformatf("vec%0d_fwd_a", i), 32'(hz.ForwardAE), 32'(vecs[i].fa));
            check($sformatf("vec%0d_fwd_b", i), 32'(hz.ForwardEE), 32'(vecs[i].fb));
        end
        @(negedge clk);
        check("ready_same_cycle_idle", 32'(dut.state), 32'(IDLE));

        // Load-use: one stall cycle, then M forwarding covers the load.
        reset_pulse();
        hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd3; hz.Rs2D = 5'd3;
        #2;
        check("lu_stalls", 32'(stalls_now()), 32'h18);
        check("lu_flushes", 32'(flushes_now()), 32'h1);
        @(negedge clk);
        clear_inputs();
        hz.RdM = 5'd3; hz.RegWriteM = 1'b1; hz.Rs2E = 5'd3;
        #2;
        check("lu_next_stalls", 32'(stalls_now()), 32'h0);
        check("lu_next_fwd_b", 32'(hz.ForwardEE), 32'(FWD_M));
        check("lu_count_1", hz.lu_count, 32'd1);
        check("lu_stall_cycles_1", hz.stall_cycles, 32'd1);

        // Branch together with load-use.
        @(negedge clk);
        clear_inputs();
        hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd4; hz.Rs1D = 5'd4; hz.PCSrcE = 1'b1;
        #2;
        check("br_lu_stalls", 32'(stalls_now()), 32'h18);
        check("br_lu_flushes", 32'(flushes_now()), 32'h3);
        @(negedge clk);
        clear_inputs();
        check("br_flush_count", hz.flush_count, 32'd1);
        check("br_lu_count", hz.lu_count, 32'd2);
        check("br_stall_cycles", hz.stall_cycles, 32'd2);

        // Four-cycle memory freeze; load-use and branch are held off meanwhile.
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            hz.mem_req_M = 1'b1; hz.mem_ready = 1'b0; hz.PCSrcE = 1'b1;
            hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
            #2;
            check($sformatf("freeze%0d_stalls", i), 32'(stalls_now()), 32'h1f);
            check($sformatf("freeze%0d_flushes", i), 32'(flushes_now()), 32'h0);
        end
        @(negedge clk);
        clear_inputs();
        hz.mem_req_M = 1'b1; hz.mem_ready = 1'b1;
        #2;
        check("freeze_wait_state", 32'(dut.state), 32'(MEM_WAIT));
        check("freeze_release_stalls", 32'(stalls_now()), 32'h0);
        @(negedge clk);
        clear_inputs();
        check("freeze_idle", 32'(dut.state), 32'(IDLE));
        check("freeze_stall_cycles", hz.stall_cycles, 32'd4);
        check("freeze_lu_count", hz.lu_count, 32'd0);
        check("freeze_flush_count", hz.flush_count, 32'd0);

        // Watchdog with MAX_WAIT=8: first edge enters MEM_WAIT, eight more set the flag.
        reset_pulse();
        hz.mem_req_M = 1'b1; hz.mem_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 8) check("wd_not_yet", 32'(hz.mem_timeout), 32'h0);
            if (k == 9) check("wd_set", 32'(hz.mem_timeout), 32'h1);
        end
        #2;
        check("wd_still_stalls", 32'(stalls_now()), 32'h1f);
        check("wd_stall_cycles", hz.stall_cycles, 32'd9);
        hz.mem_ready = 1'b1;
        @(negedge clk);
        check("wd_ready_idle", 32'(dut.state), 32'(IDLE));
        check("wd_sticky_1", 32'(hz.mem_timeout), 32'h1);
        clear_inputs();
        @(negedge clk);
        check("wd_sticky_2", 32'(hz.mem_timeout), 32'h1);

        // Reset in the middle of a wait.
        hz.mem_req_M = 1'b1; hz.mem_ready = 1'b0; hz.PCSrcE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_in_wait", 32'(dut.state), 32'(MEM_WAIT));
        reset = 1'b1;
        #2;
        check("midrst_stalls", 32'(stalls_now()), 32'h0);
        check("midrst_flushes", 32'(flushes_now()), 32'h3);
        @(negedge clk);
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        check("midrst_timeout", 32'(hz.mem_timeout), 32'h0);
        check("midrst_stall_cycles", hz.stall_cycles, 32'd0);
        check("midrst_flush_count", hz.flush_count, 32'd0);
        reset = 1'b0;
        clear_inputs();

        // 2-bit counter saturates at 3 and stays there.
        hz2.PCSrcE = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("sat_flush_%0d", k), 32'(hz2.flush_count), (k < 3) ? k : 3);
        end
        hz2.PCSrcE = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
